// File: rtl/qrisc32_mem_arb_if.sv
// Bundle of the fetch, data and memory-side signals around the qrisc32 memory arbiter.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface qrisc32_mem_arb_if;
  logic        flush;

  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_ready;
  logic        irsp_valid;
  logic [31:0] irsp_data;

  logic        dreq_valid;
  logic        dreq_we;
  logic [31:0] dreq_addr;
  logic [31:0] dreq_wdata;
  logic        dreq_ready;
  logic        drsp_valid;
  logic [31:0] drsp_data;

  logic        rsp_err;
  logic        pipe_stall;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  flush,
    input  ireq_valid, ireq_addr,
    output ireq_ready, irsp_valid, irsp_data,
    input  dreq_valid, dreq_we, dreq_addr, dreq_wdata,
    output dreq_ready, drsp_valid, drsp_data,
    output rsp_err, pipe_stall,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport master (
    output flush,
    output ireq_valid, ireq_addr,
    input  ireq_ready, irsp_valid, irsp_data,
    output dreq_valid, dreq_we, dreq_addr, dreq_wdata,
    input  dreq_ready, drsp_valid, drsp_data,
    input  rsp_err, pipe_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/qrisc32_mem_arb.sv
// Single-port memory arbiter for qrisc32: shares the memory bus between instruction
// fetch (I) and the EX/MEM data path (D), with a D-burst fairness cap and a bus timeout.
module qrisc32_mem_arb #(
  parameter int unsigned DBURST_MAX = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic               clk,
  input  logic               areset,
  qrisc32_mem_arb_if.slave   bus
);

  localparam int unsigned DW = $clog2(DBURST_MAX + 1);
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t        state_q,       state_d;
  logic [DW-1:0] dcnt_q,        dcnt_d;
  logic [TW-1:0] tcnt_q,        tcnt_d;
  logic          drop_q,        drop_d;
  logic          mem_req_q,     mem_req_d;
  logic          mem_we_q,      mem_we_d;
  logic [31:0]   mem_addr_q,    mem_addr_d;
  logic [31:0]   mem_wdata_q,   mem_wdata_d;
  logic          ireq_ready_q,  ireq_ready_d;
  logic          dreq_ready_q,  dreq_ready_d;
  logic          irsp_valid_q,  irsp_valid_d;
  logic [31:0]   irsp_data_q,   irsp_data_d;
  logic          drsp_valid_q,  drsp_valid_d;
  logic [31:0]   drsp_data_q,   drsp_data_d;
  logic          rsp_err_q,     rsp_err_d;

  logic i_want, d_cap, timeout, is_i, drop_now, done;

  // A fetch request arriving together with a flush is stale and is never granted.
  assign i_want   = bus.ireq_valid & ~bus.flush;
  assign d_cap    = (dcnt_q == DW'(DBURST_MAX));
  assign timeout  = (tcnt_q == TW'(TIMEOUT - 1));
  assign is_i     = (state_q == BUSY_I);
  assign drop_now = drop_q | bus.flush;
  assign done     = bus.mem_ack | timeout;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    dcnt_d       = dcnt_q;
    tcnt_d       = tcnt_q;
    drop_d       = drop_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    ireq_ready_d = 1'b0;
    dreq_ready_d = 1'b0;
    irsp_valid_d = 1'b0;
    irsp_data_d  = '0;
    drsp_valid_d = 1'b0;
    drsp_data_d  = '0;
    rsp_err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!bus.ireq_valid) dcnt_d = '0;
        if (bus.dreq_valid && !(i_want && d_cap)) begin
          state_d      = BUSY_D;
          mem_req_d    = 1'b1;
          dreq_ready_d = 1'b1;
          mem_we_d     = bus.dreq_we;
          mem_addr_d   = bus.dreq_addr;
          mem_wdata_d  = bus.dreq_wdata;
          tcnt_d       = '0;
          // Only D grants made while I is waiting count toward the fairness cap.
          if (bus.ireq_valid && !d_cap) dcnt_d = dcnt_q + DW'(1);
        end else if (i_want) begin
          state_d      = BUSY_I;
          mem_req_d    = 1'b1;
          ireq_ready_d = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = bus.ireq_addr;
          mem_wdata_d  = '0;
          tcnt_d       = '0;
          dcnt_d       = '0;
          drop_d       = 1'b0;
        end
      end

      BUSY_I, BUSY_D: begin
        if (done) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          if (is_i) begin
            // A flushed fetch still completes on the bus but returns nothing.
            if (!drop_now) begin
              irsp_valid_d = 1'b1;
              irsp_data_d  = bus.mem_ack ? bus.mem_rdata : '0;
              rsp_err_d    = ~bus.mem_ack;
            end
          end else begin
            drsp_valid_d = 1'b1;
            drsp_data_d  = (bus.mem_ack && !mem_we_q) ? bus.mem_rdata : '0;
            rsp_err_d    = ~bus.mem_ack;
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
          if (is_i) drop_d = drop_now;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (areset) begin
      state_q      <= IDLE;
      dcnt_q       <= '0;
      tcnt_q       <= '0;
      drop_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ireq_ready_q <= 1'b0;
      dreq_ready_q <= 1'b0;
      irsp_valid_q <= 1'b0;
      irsp_data_q  <= '0;
      drsp_valid_q <= 1'b0;
      drsp_data_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dcnt_q       <= dcnt_d;
      tcnt_q       <= tcnt_d;
      drop_q       <= drop_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      ireq_ready_q <= ireq_ready_d;
      dreq_ready_q <= dreq_ready_d;
      irsp_valid_q <= irsp_valid_d;
      irsp_data_q  <= irsp_data_d;
      drsp_valid_q <= drsp_valid_d;
      drsp_data_q  <= drsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.ireq_ready = ireq_ready_q;
  assign bus.irsp_valid = irsp_valid_q;
  assign bus.irsp_data  = irsp_data_q;
  assign bus.dreq_ready = dreq_ready_q;
  assign bus.drsp_valid = drsp_valid_q;
  assign bus.drsp_data  = drsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  // EX must hold from the moment it asks until the data access leaves the bus.
  assign bus.pipe_stall = bus.dreq_valid | (state_q == BUSY_D);

endmodule
